// File: rtl/state_machine_pkg.sv
// Shared types and defaults for the BIST sequencer (state_machine).
// The optional abort feature is controlled by the STATE_MACHINE_ABORT_EN macro.
package state_machine_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      INIT    = 2'd1,
      RUNNING = 2'd2,
      FINISH  = 2'd3
   } state_t;

   localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/state_machine_if.sv
// Control/status bundle between the system controller, the BIST sequencer and the BIST datapath.
// The abort pulse exists only when STATE_MACHINE_ABORT_EN is defined.
interface state_machine_if;

   logic bist_start;
   logic mode;
   logic bist_end;
   logic init;
   logic running;
   logic finish;
`ifdef STATE_MACHINE_ABORT_EN
   logic abort;
`endif

   modport slave (
      input  bist_start,
      output mode, bist_end, init, running, finish
`ifdef STATE_MACHINE_ABORT_EN
      , output abort
`endif
   );

   modport master (
      output bist_start,
      input  mode, bist_end, init, running, finish
`ifdef STATE_MACHINE_ABORT_EN
      , input abort
`endif
   );

endinterface

// File: rtl/state_machine_edge_detect_rise.sv
// Rising-edge detector: registers the input once per cycle and flags a 0->1 transition.
module edge_detect_rise (
   input  logic clock,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   always_ff @(posedge clock) begin
      if (reset) sig_q <= 1'b0;
      else       sig_q <= sig;
   end

   // A level already high when reset releases reads as a rise, because history starts at 0.
   assign rise = sig & ~sig_q;

endmodule

// File: rtl/state_machine.sv
// BIST sequencer: IDLE -> INIT -> RUNNING -> FINISH -> IDLE on a rising bist_start.
// Define STATE_MACHINE_ABORT_EN to let a low bist_start abort INIT/RUNNING early.
module state_machine
   import state_machine_pkg::*;
#(
   parameter int INIT_CYCLES = 2,
   parameter int RUN_CYCLES  = 8,
   parameter int CNT_W       = CNT_W_DEFAULT
) (
   input logic            clock,
   input logic            reset,
   state_machine_if.slave bus
);

   if (INIT_CYCLES < 1 || INIT_CYCLES > 255) begin : g_bad_init
      $error("state_machine: INIT_CYCLES must be 1..255");
   end
   if (RUN_CYCLES < 1 || RUN_CYCLES > 65535) begin : g_bad_run
      $error("state_machine: RUN_CYCLES must be 1..65535");
   end
   if (CNT_W < 1 || CNT_W > 32 ||
       (64'(INIT_CYCLES - 1) >> CNT_W) != 64'd0 ||
       (64'(RUN_CYCLES - 1) >> CNT_W) != 64'd0) begin : g_bad_width
      $error("state_machine: CNT_W too narrow for INIT_CYCLES/RUN_CYCLES");
   end

   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] counter, counter_n;
   logic             done_q, done_n;
   logic             start_rise;
`ifdef STATE_MACHINE_ABORT_EN
   logic             aborted, aborted_n;
`endif

   edge_detect_rise u_start_edge (
      .clock (clock),
      .reset (reset),
      .sig   (bus.bist_start),
      .rise  (start_rise)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         counter <= '0;
         done_q  <= 1'b0;
`ifdef STATE_MACHINE_ABORT_EN
         aborted <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         counter <= counter_n;
         done_q  <= done_n;
`ifdef STATE_MACHINE_ABORT_EN
         aborted <= aborted_n;
`endif
      end
   end

   // The counter measures time spent in the current phase and restarts at every phase change.
   always_comb begin
      state_n   = state;
      counter_n = counter;
      done_n    = done_q;
`ifdef STATE_MACHINE_ABORT_EN
      aborted_n = aborted;
`endif
      case (state)
         IDLE: begin
            if (start_rise) begin
               state_n   = INIT;
               counter_n = '0;
               done_n    = 1'b0;
            end
         end
         INIT: begin
            if (counter == INIT_LAST) begin
               state_n   = RUNNING;
               counter_n = '0;
            end else begin
               counter_n = counter + 1'b1;
            end
         end
         RUNNING: begin
            if (counter == RUN_LAST) begin
               state_n   = FINISH;
               counter_n = '0;
            end else begin
               counter_n = counter + 1'b1;
            end
         end
         FINISH: begin
            state_n   = IDLE;
            counter_n = '0;
`ifdef STATE_MACHINE_ABORT_EN
            done_n    = ~aborted;
            aborted_n = 1'b0;
`else
            done_n    = 1'b1;
`endif
         end
         default: begin
            state_n   = IDLE;
            counter_n = '0;
         end
      endcase
`ifdef STATE_MACHINE_ABORT_EN
      // Dropping the request mid-test cuts straight to a single FINISH cycle that reports abort.
      if ((state == INIT || state == RUNNING) && !bus.bist_start) begin
         state_n   = FINISH;
         counter_n = '0;
         aborted_n = 1'b1;
      end
`endif
   end

   assign bus.init     = (state == INIT);
   assign bus.running  = (state == RUNNING);
   assign bus.finish   = (state == FINISH);
   assign bus.mode     = (state != IDLE);
   assign bus.bist_end = done_q;
`ifdef STATE_MACHINE_ABORT_EN
   assign bus.abort    = aborted;
`endif

endmodule

// File: tb/tb_state_machine.sv
// Directed self-checking bench for the BIST sequencer with default parameters.
// Output vector layout: {abort, mode, init, running, finish, bist_end}.
module tb_state_machine;

   logic clock = 1'b0;
   logic reset;
   int   compared   = 0;
   int   mismatched = 0;

   state_machine_if bus ();

   state_machine dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_INIT  = 6'b011000;
   localparam logic [5:0] O_RUN   = 6'b010100;
   localparam logic [5:0] O_FIN   = 6'b010010;
   localparam logic [5:0] O_DONE  = 6'b000001;
   localparam logic [5:0] O_ABORT = 6'b110010;

   function automatic logic [5:0] observed();
      logic ab;
      ab = 1'b0;
`ifdef STATE_MACHINE_ABORT_EN
      ab = bus.abort;
`endif
      return {ab, bus.mode, bus.init, bus.running, bus.finish, bus.bist_end};
   endfunction

   task automatic checkOutput(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   // Drive inputs, then move just past the next rising edge so outputs are stable when sampled.
   task automatic applyStimulus(input logic rst, input logic start);
      reset          = rst;
      bus.bist_start = start;
      @(posedge clock);
      #1;
   endtask

   // Index i counts edges after the accepted start edge (i = 0 is that edge).
   function automatic logic [5:0] runExpect(input int i);
      if (i < 2)       return O_INIT;
      else if (i < 10) return O_RUN;
      else if (i == 10) return O_FIN;
      else             return O_DONE;
   endfunction

   // One complete run; pulseAt >= 0 drops bist_start after that index, raises it once, then drops it.
   task automatic runBist(input int pulseAt, input string tag);
      logic start;
      applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 14; i++) begin
         checkOutput($sformatf("%s[%0d]", tag, i), observed(), runExpect(i));
         if (pulseAt < 0) start = 1'b1;
         else             start = (i < pulseAt) || (i == pulseAt + 1);
         if (i < 13) applyStimulus(1'b0, start);
      end
   endtask

   initial begin
      reset          = 1'b1;
      bus.bist_start = 1'b0;

      applyStimulus(1'b1, 1'b0);
      checkOutput("reset", observed(), O_IDLE);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0);
         checkOutput($sformatf("idle[%0d]", i), observed(), O_IDLE);
      end

      runBist(-1, "run_held");

      applyStimulus(1'b0, 1'b0);
      checkOutput("drop_keeps_done", observed(), O_DONE);
      applyStimulus(1'b0, 1'b1);
      checkOutput("restart_init0", observed(), O_INIT);
      applyStimulus(1'b0, 1'b1);
      checkOutput("restart_init1", observed(), O_INIT);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput($sformatf("restart_run[%0d]", i), observed(), O_RUN);
      end

      applyStimulus(1'b1, 1'b0);
      checkOutput("midrun_reset", observed(), O_IDLE);
      applyStimulus(1'b1, 1'b0);
      checkOutput("midrun_reset_hold", observed(), O_IDLE);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b0);
         checkOutput($sformatf("post_reset[%0d]", i), observed(), O_IDLE);
      end

`ifndef STATE_MACHINE_ABORT_EN
      runBist(3, "run_pulse");
      applyStimulus(1'b0, 1'b0);
      checkOutput("pulse_after", observed(), O_DONE);
`else
      applyStimulus(1'b0, 1'b1);
      checkOutput("abort_init0", observed(), O_INIT);
      applyStimulus(1'b0, 1'b1);
      checkOutput("abort_init1", observed(), O_INIT);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput($sformatf("abort_run[%0d]", i), observed(), O_RUN);
      end
      applyStimulus(1'b0, 1'b0);
      checkOutput("abort_finish", observed(), O_ABORT);
      applyStimulus(1'b0, 1'b0);
      checkOutput("abort_idle", observed(), O_IDLE);
      applyStimulus(1'b0, 1'b0);
      checkOutput("abort_idle_hold", observed(), O_IDLE);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
